// File: rtl/pc_fetch_pkg.sv
// Shared IFU definitions: fetch FSM state encodings, reset PC and branch kinds.
package pc_fetch_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'hBFC0_0000;

  typedef enum logic [2:0] {
    FETCH_IDLE    = 3'd0,
    FETCH_REQ     = 3'd1,
    FETCH_WAIT    = 3'd2,
    FETCH_HOLD    = 3'd3,
    FETCH_DISCARD = 3'd4
  } fetchState_e;

  typedef enum logic [1:0] {
    BR_NONE     = 2'd0,
    BR_COND     = 2'd1,
    BR_JUMP     = 2'd2,
    BR_JUMP_REG = 2'd3
  } branchKind_e;

  // An 8-byte fetch pair is only usable when it starts on an 8-byte boundary.
  function automatic logic pairFits(input logic [31:0] addr);
    return ~addr[2];
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register plus request/response FSM toward instruction memory.
// Define IFU_DUAL_FETCH_EN to enable the second delivery slot (inst_addr+4).
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        flush_req,
  input  logic        stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata_1,
  input  logic [31:0] inst_rdata_2,
  output logic [31:0] pc,
  output logic        inst_rdata_1_ok,
  output logic        inst_rdata_2_ok,
  output logic [31:0] if_inst_1,
  output logic [31:0] if_inst_2
);

  fetchState_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] heldInst1_q, heldInst1_d;
  logic        deliverLive;
  logic        deliverHeld;
  logic        captureEn;
  logic        releaseHeld;

  // A redirect must land in the PC even while decode is stalled.
  assign pc_d = (!stall || flush_req) ? next_pc : pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_PC;
      heldInst1_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      heldInst1_q <= heldInst1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    inst_req    = 1'b0;
    deliverLive = 1'b0;
    deliverHeld = 1'b0;
    captureEn   = 1'b0;
    releaseHeld = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        inst_req = 1'b1;
        if (inst_addr_ok) begin
          state_d = flush_req ? FETCH_DISCARD : FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (inst_data_ok) begin
          if (flush_req) begin
            state_d = FETCH_REQ;
          end else if (stall) begin
            state_d   = FETCH_HOLD;
            captureEn = 1'b1;
          end else begin
            state_d     = FETCH_REQ;
            deliverLive = 1'b1;
          end
        end else if (flush_req) begin
          state_d = FETCH_DISCARD;
        end
      end
      FETCH_HOLD: begin
        if (flush_req) begin
          state_d     = FETCH_REQ;
          releaseHeld = 1'b1;
        end else if (!stall) begin
          state_d     = FETCH_REQ;
          deliverHeld = 1'b1;
          releaseHeld = 1'b1;
        end
      end
      FETCH_DISCARD: begin
        if (inst_data_ok) begin
          state_d = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_comb begin
    heldInst1_d = heldInst1_q;
    if (captureEn) begin
      heldInst1_d = inst_rdata_1;
    end else if (releaseHeld) begin
      heldInst1_d = '0;
    end
  end

  assign inst_addr       = pc_q;
  assign pc              = pc_q;
  assign inst_rdata_1_ok = deliverLive | deliverHeld;

  always_comb begin
    if_inst_1 = '0;
    if (deliverLive) begin
      if_inst_1 = inst_rdata_1;
    end else if (deliverHeld) begin
      if_inst_1 = heldInst1_q;
    end
  end

`ifdef IFU_DUAL_FETCH_EN
  logic [31:0] heldInst2_q, heldInst2_d;
  logic        heldOk2_q, heldOk2_d;
  logic        pairOk;

  assign pairOk = pairFits(pc_q);

  // Slot-2 validity is frozen at capture so a held pair is judged by the PC it was fetched for.
  always_comb begin
    heldInst2_d = heldInst2_q;
    heldOk2_d   = heldOk2_q;
    if (captureEn) begin
      heldInst2_d = pairOk ? inst_rdata_2 : '0;
      heldOk2_d   = pairOk;
    end else if (releaseHeld) begin
      heldInst2_d = '0;
      heldOk2_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      heldInst2_q <= '0;
      heldOk2_q   <= 1'b0;
    end else begin
      heldInst2_q <= heldInst2_d;
      heldOk2_q   <= heldOk2_d;
    end
  end

  assign inst_rdata_2_ok = (deliverLive & pairOk) | (deliverHeld & heldOk2_q);

  always_comb begin
    if_inst_2 = '0;
    if (deliverLive && pairOk) begin
      if_inst_2 = inst_rdata_2;
    end else if (deliverHeld && heldOk2_q) begin
      if_inst_2 = heldInst2_q;
    end
  end
`else
  logic unused_slot2;

  assign unused_slot2    = ^inst_rdata_2;
  assign inst_rdata_2_ok = 1'b0;
  assign if_inst_2       = '0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: acts as npc and instruction memory, scoreboards delivered words.
module tb_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef IFU_DUAL_FETCH_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] next_pc;
  logic        flushReq;
  logic [31:0] flushTarget;
  logic        stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata_1;
  logic [31:0] inst_rdata_2;
  logic [31:0] pc;
  logic        inst_rdata_1_ok;
  logic        inst_rdata_2_ok;
  logic [31:0] if_inst_1;
  logic [31:0] if_inst_2;
  logic [31:0] reqAddr;

  typedef struct {
    int          addrWait;
    int          dataWait;
    int          stallCycles;
    bit          redirect;
    logic [31:0] target;
    logic [31:0] expAddr;
    logic        expOk2;
    logic [31:0] expNext;
  } vec_t;

  typedef struct {
    logic        ok2;
    logic [31:0] w1;
    logic [31:0] w2;
  } exp_t;

  exp_t sbQueue[$];
  int   checks = 0;
  int   errors = 0;

  pc_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .next_pc         (next_pc),
    .flush_req       (flushReq),
    .stall           (stall),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata_1    (inst_rdata_1),
    .inst_rdata_2    (inst_rdata_2),
    .pc              (pc),
    .inst_rdata_1_ok (inst_rdata_1_ok),
    .inst_rdata_2_ok (inst_rdata_2_ok),
    .if_inst_1       (if_inst_1),
    .if_inst_2       (if_inst_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // npc stand-in: advance by what decode actually received, or redirect
  always_comb begin
    if (flushReq) next_pc = flushTarget;
    else if (inst_rdata_2_ok) next_pc = pc + 32'd8;
    else if (inst_rdata_1_ok) next_pc = pc + 32'd4;
    else next_pc = pc;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h3C5A_96F0;
  endfunction

  function automatic vec_t makeRow(input bit redirect, input logic [31:0] target,
                                   input logic [31:0] cur, input int aw, input int dw,
                                   input int sc);
    vec_t v;
    v.addrWait    = aw;
    v.dataWait    = dw;
    v.stallCycles = sc;
    v.redirect    = redirect;
    v.target      = target;
    v.expAddr     = redirect ? target : cur;
    v.expOk2      = DUAL && !v.expAddr[2];
    v.expNext     = v.expAddr + (v.expOk2 ? 32'd8 : 32'd4);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every delivery must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (inst_rdata_1_ok) begin
        if (sbQueue.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ok: got ok1=1 expected 0 at %0t", $time);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("slot1 word", if_inst_1, e.w1);
          checkOutput("slot2 ok", {31'b0, inst_rdata_2_ok}, {31'b0, e.ok2});
          checkOutput("slot2 word", if_inst_2, e.w2);
        end
      end else begin
        checkOutput("quiet ok2", {31'b0, inst_rdata_2_ok}, 32'd0);
        checkOutput("quiet inst1", if_inst_1, 32'd0);
        checkOutput("quiet inst2", if_inst_2, 32'd0);
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    if (v.redirect) begin
      flushReq    = 1'b1;
      flushTarget = v.target;
      @(negedge clk);
      checkOutput("redirect req", {31'b0, inst_req}, 32'd1);
      tick();
      flushReq = 1'b0;
    end
    for (int i = 0; i < v.addrWait; i++) begin
      @(negedge clk);
      checkOutput("req addr", inst_addr, v.expAddr);
      checkOutput("req valid", {31'b0, inst_req}, 32'd1);
      tick();
    end
    inst_addr_ok = 1'b1;
    @(negedge clk);
    checkOutput("req addr", inst_addr, v.expAddr);
    checkOutput("req valid", {31'b0, inst_req}, 32'd1);
    reqAddr = inst_addr;
    tick();
    inst_addr_ok = 1'b0;
    stall = (v.stallCycles > 0);
    for (int i = 0; i < v.dataWait; i++) begin
      @(negedge clk);
      checkOutput("wait no req", {31'b0, inst_req}, 32'd0);
      tick();
    end
    inst_data_ok = 1'b1;
    inst_rdata_1 = memWord(reqAddr);
    inst_rdata_2 = memWord(reqAddr + 32'd4);
    e.ok2 = v.expOk2;
    e.w1  = memWord(v.expAddr);
    e.w2  = v.expOk2 ? memWord(v.expAddr + 32'd4) : 32'd0;
    sbQueue.push_back(e);
    @(negedge clk);
    checkOutput("data ok1", {31'b0, inst_rdata_1_ok}, (v.stallCycles == 0) ? 32'd1 : 32'd0);
    tick();
    inst_data_ok = 1'b0;
    inst_rdata_1 = $urandom;
    inst_rdata_2 = $urandom;
    if (v.stallCycles > 0) begin
      for (int k = 1; k < v.stallCycles; k++) begin
        @(negedge clk);
        checkOutput("hold ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
        checkOutput("hold pc", pc, v.expAddr);
        tick();
      end
      stall = 1'b0;
      @(negedge clk);
      checkOutput("release ok1", {31'b0, inst_rdata_1_ok}, 32'd1);
      tick();
    end
    @(negedge clk);
    checkOutput("next pc", pc, v.expNext);
    checkOutput("next req", {31'b0, inst_req}, 32'd1);
    tick();
  endtask

  vec_t        vecs[7];
  logic [31:0] cur;

  initial begin
    rst          = 1'b1;
    flushReq     = 1'b0;
    flushTarget  = '0;
    stall        = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata_1 = '0;
    inst_rdata_2 = '0;
    reqAddr      = '0;

    cur = RESET_PC;
    vecs[0] = makeRow(1'b0, 32'h0, cur, 0, 1, 0);                cur = vecs[0].expNext;
    vecs[1] = makeRow(1'b0, 32'h0, cur, 2, 0, 0);                cur = vecs[1].expNext;
    vecs[2] = makeRow(1'b0, 32'h0, cur, 1, 2, 3);                cur = vecs[2].expNext;
    vecs[3] = makeRow(1'b1, 32'hBFC0_0004, cur, 0, 1, 0);        cur = vecs[3].expNext;
    vecs[4] = makeRow(1'b0, 32'h0, cur, 0, 0, 2);                cur = vecs[4].expNext;
    vecs[5] = makeRow(1'b1, 32'h8000_0010, cur, 3, 1, 0);        cur = vecs[5].expNext;
    vecs[6] = makeRow(1'b1, 32'h8000_001C, cur, 0, 0, 1);        cur = vecs[6].expNext;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req", {31'b0, inst_req}, 32'd0);
    checkOutput("reset pc", pc, RESET_PC);
    checkOutput("reset ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
    checkOutput("reset inst1", if_inst_1, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle req", {31'b0, inst_req}, 32'd0);
    tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
    end

    // Redirect while waiting for data: the late response must be dropped
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    flushReq     = 1'b1;
    flushTarget  = 32'h8000_0100;
    @(negedge clk);
    checkOutput("wait flush req", {31'b0, inst_req}, 32'd0);
    tick();
    flushReq = 1'b0;
    @(negedge clk);
    checkOutput("discard req", {31'b0, inst_req}, 32'd0);
    tick();
    inst_data_ok = 1'b1;
    inst_rdata_1 = 32'hDEAD_0001;
    inst_rdata_2 = 32'hDEAD_0002;
    @(negedge clk);
    checkOutput("discard ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
    tick();
    inst_data_ok = 1'b0;
    applyStimulus(makeRow(1'b0, 32'h0, 32'h8000_0100, 0, 1, 0));

    // Redirect in the same cycle the address is accepted
    inst_addr_ok = 1'b1;
    flushReq     = 1'b1;
    flushTarget  = 32'h8000_0200;
    tick();
    inst_addr_ok = 1'b0;
    flushReq     = 1'b0;
    @(negedge clk);
    checkOutput("discard2 req", {31'b0, inst_req}, 32'd0);
    tick();
    inst_data_ok = 1'b1;
    @(negedge clk);
    checkOutput("discard2 ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
    tick();
    inst_data_ok = 1'b0;
    applyStimulus(makeRow(1'b0, 32'h0, 32'h8000_0200, 1, 0, 0));

    // Redirect coincident with returning data
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    flushReq     = 1'b1;
    flushTarget  = 32'h8000_0300;
    @(negedge clk);
    checkOutput("flush data ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
    tick();
    inst_data_ok = 1'b0;
    flushReq     = 1'b0;
    applyStimulus(makeRow(1'b0, 32'h0, 32'h8000_0300, 0, 0, 0));

    // Redirect while holding stalled data
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata_1 = 32'hBAD0_0001;
    stall        = 1'b1;
    @(negedge clk);
    checkOutput("hold cap ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
    tick();
    inst_data_ok = 1'b0;
    flushReq     = 1'b1;
    flushTarget  = 32'h8000_0400;
    @(negedge clk);
    checkOutput("hold flush ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
    tick();
    flushReq = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    checkOutput("post hold ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
    checkOutput("post hold addr", inst_addr, 32'h8000_0400);
    tick();
    applyStimulus(makeRow(1'b0, 32'h0, 32'h8000_0400, 0, 1, 2));

    // Reset with a request outstanding
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset req", {31'b0, inst_req}, 32'd0);
    checkOutput("midreset pc", pc, RESET_PC);
    checkOutput("midreset ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset idle", {31'b0, inst_req}, 32'd0);
    tick();
    applyStimulus(makeRow(1'b0, 32'h0, RESET_PC, 0, 1, 0));

    checkOutput("scoreboard drained", sbQueue.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
